// File: rtl/mantissa_divider_28.sv
// Lane-partitioned restoring mantissa divider: one 28-bit, two 14-bit or four 7-bit
// fixed-point 1.(W-1) divides, one quotient bit per lane per cycle on a shared 28-bit datapath.
module mantissa_divider_28 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] A,
    input  logic [27:0] B,
    input  logic [1:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [55:0] out,
    output logic [3:0]  dz,
    output logic [3:0]  ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_28 = 2'd0;
    localparam logic [1:0] MODE_14 = 2'd1;
    localparam logic [1:0] MODE_7  = 2'd2;

    state_t state_reg, state_next;

    logic [1:0]  mode_reg, mode_in;
    logic [27:0] a_reg, b_reg, rem_reg, quo_reg;
    logic [3:0]  hi_reg, hi_next;
    logic [4:0]  cnt_reg, cnt_last;
    logic [3:0]  dz_flag_reg, ovf_flag_reg, dz_in, ovf_in;
    logic [55:0] out_reg;
    logic [3:0]  dz_reg, ovf_reg;
    logic        accept, last_iter;

    logic [3:0][1:0] lane_idx;
    logic [3:0]      lane_start, lane_top;
    logic [27:0]     diff, rem_sel, rem_shift, quo_shift, q_final, r_final;
    logic [3:0]      lane_ge, chunk_ge;

    assign mode_in   = (op == 2'b11) ? MODE_28 : op;
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_reg == cnt_last);

    // Map each 7-bit chunk to its lane and mark where lanes begin and end.
    always_comb begin
        lane_idx   = '0;
        lane_start = '0;
        lane_top   = '0;
        for (int c = 0; c < 4; c++) begin
            case (mode_reg)
                MODE_14: begin
                    lane_idx[c]   = 2'(c / 2);
                    lane_start[c] = (c % 2 == 0);
                    lane_top[c]   = (c % 2 == 1);
                end
                MODE_7: begin
                    lane_idx[c]   = 2'(c);
                    lane_start[c] = 1'b1;
                    lane_top[c]   = 1'b1;
                end
                default: begin
                    lane_idx[c]   = 2'd0;
                    lane_start[c] = (c == 0);
                    lane_top[c]   = (c == 3);
                end
            endcase
        end
    end

    always_comb begin
        case (mode_reg)
            MODE_14: cnt_last = 5'd13;
            MODE_7:  cnt_last = 5'd6;
            default: cnt_last = 5'd27;
        endcase
    end

    // Segmented subtract: the borrow chain is cut at every lane boundary. The partial
    // remainder is {hi, low W bits}; a set hi bit already guarantees it exceeds B.
    always_comb begin : sub_chain
        logic       borrow;
        logic [7:0] full;
        borrow  = 1'b0;
        full    = '0;
        diff    = '0;
        lane_ge = '0;
        for (int c = 0; c < 4; c++) begin
            if (lane_start[c]) begin
                borrow = 1'b0;
            end
            full = {1'b0, rem_reg[c*7 +: 7]} - {1'b0, b_reg[c*7 +: 7]} - {7'd0, borrow};
            diff[c*7 +: 7] = full[6:0];
            borrow = full[7];
            if (lane_top[c]) begin
                lane_ge[lane_idx[c]] = hi_reg[lane_idx[c]] | ~borrow;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chunk
            assign chunk_ge[gi] = lane_ge[lane_idx[gi]];
            assign rem_sel[gi*7 +: 7] = chunk_ge[gi] ? diff[gi*7 +: 7] : rem_reg[gi*7 +: 7];

            if (gi == 0) begin : g_first
                assign rem_shift[6:0] = {rem_sel[5:0], 1'b0};
                assign quo_shift[6:0] = {quo_reg[5:0], chunk_ge[0]};
            end else begin : g_rest
                assign rem_shift[gi*7 +: 7] =
                    {rem_sel[gi*7 +: 6], lane_start[gi] ? 1'b0 : rem_sel[gi*7-1]};
                assign quo_shift[gi*7 +: 7] =
                    {quo_reg[gi*7 +: 6], lane_start[gi] ? chunk_ge[gi] : quo_reg[gi*7-1]};
            end

            assign q_final[gi*7 +: 7] =
                (dz_flag_reg[lane_idx[gi]] || ovf_flag_reg[lane_idx[gi]]) ? 7'h7F
                                                                           : quo_shift[gi*7 +: 7];
            assign r_final[gi*7 +: 7] =
                dz_flag_reg[lane_idx[gi]]  ? a_reg[gi*7 +: 7] :
                ovf_flag_reg[lane_idx[gi]] ? 7'h00 : rem_sel[gi*7 +: 7];
        end
    endgenerate

    always_comb begin
        hi_next = '0;
        for (int c = 0; c < 4; c++) begin
            if (lane_top[c]) begin
                hi_next[lane_idx[c]] = rem_sel[c*7 + 6];
            end
        end
    end

    // Special cases are decided from the raw operands; A >= 2B is the same test as A>>1 >= B.
    always_comb begin
        dz_in  = '0;
        ovf_in = '0;
        case (mode_in)
            MODE_14: begin
                for (int l = 0; l < 2; l++) begin
                    dz_in[l]  = (B[l*14 +: 14] == 14'd0);
                    ovf_in[l] = !dz_in[l] && ({1'b0, A[l*14+1 +: 13]} >= B[l*14 +: 14]);
                end
            end
            MODE_7: begin
                for (int l = 0; l < 4; l++) begin
                    dz_in[l]  = (B[l*7 +: 7] == 7'd0);
                    ovf_in[l] = !dz_in[l] && ({1'b0, A[l*7+1 +: 6]} >= B[l*7 +: 7]);
                end
            end
            default: begin
                dz_in[0]  = (B == 28'd0);
                ovf_in[0] = !dz_in[0] && ({1'b0, A[27:1]} >= B);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    assign out = out_reg;
    assign dz  = dz_reg;
    assign ovf = ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg     <= MODE_28;
            a_reg        <= '0;
            b_reg        <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            hi_reg       <= '0;
            cnt_reg      <= '0;
            dz_flag_reg  <= '0;
            ovf_flag_reg <= '0;
            out_reg      <= '0;
            dz_reg       <= '0;
            ovf_reg      <= '0;
        end else begin
            if (accept) begin
                mode_reg     <= mode_in;
                a_reg        <= A;
                b_reg        <= B;
                rem_reg      <= A;
                quo_reg      <= '0;
                hi_reg       <= '0;
                cnt_reg      <= '0;
                dz_flag_reg  <= dz_in;
                ovf_flag_reg <= ovf_in;
            end else if (state_reg == BUSY) begin
                quo_reg <= quo_shift;
                hi_reg  <= hi_next;
                if (last_iter) begin
                    // Final step keeps the remainder unshifted and publishes the result.
                    rem_reg <= rem_sel;
                    cnt_reg <= '0;
                    out_reg <= {r_final, q_final};
                    dz_reg  <= dz_flag_reg;
                    ovf_reg <= ovf_flag_reg;
                end else begin
                    rem_reg <= rem_shift;
                    cnt_reg <= cnt_reg + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mantissa_divider_28.sv
// Directed and randomized checks of mantissa_divider_28 against an arithmetic lane model.
module tb_mantissa_divider_28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] A = '0;
    logic [27:0] B = '0;
    logic [1:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [55:0] out;
    logic [3:0]  dz;
    logic [3:0]  ovf;

    int n_checks = 0;
    int n_fail   = 0;

    mantissa_divider_28 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Q = floor(A * 2^(W-1) / B), R = A * 2^(W-1) - Q * B, with dz / overflow overrides.
    function automatic void model(input logic [1:0] m, input logic [27:0] a, input logic [27:0] b,
                                  output logic [55:0] res, output logic [3:0] dzx,
                                  output logic [3:0] ovx, output int w);
        longint unsigned al, bl, q, r, mask, qacc, racc;
        w    = (m == 2'd1) ? 14 : (m == 2'd2) ? 7 : 28;
        mask = (64'd1 << w) - 64'd1;
        qacc = 0;
        racc = 0;
        dzx  = '0;
        ovx  = '0;
        for (int k = 0; k < 28 / w; k++) begin
            al = (64'(a) >> (k * w)) & mask;
            bl = (64'(b) >> (k * w)) & mask;
            if (bl == 0) begin
                dzx[k] = 1'b1;
                q = mask;
                r = al;
            end else if (al >= 2 * bl) begin
                ovx[k] = 1'b1;
                q = mask;
                r = 0;
            end else begin
                q = (al << (w - 1)) / bl;
                r = (al << (w - 1)) - q * bl;
            end
            qacc |= q << (k * w);
            racc |= r << (k * w);
        end
        res = {racc[27:0], qacc[27:0]};
    endfunction

    task automatic run_op(input logic [1:0] m, input logic [27:0] a, input logic [27:0] b,
                          input int stall, input string tag);
        logic [55:0] exp_out;
        logic [3:0]  exp_dz, exp_ovf;
        int          w, lat;
        model(m, a, b, exp_out, exp_dz, exp_ovf, w);
        op       = m;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        // Scramble inputs and keep in_valid high while busy; none of it may matter.
        A  = 28'($urandom);
        B  = 28'($urandom);
        op = 2'($urandom);
        out_ready = (stall == 0);
        chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'(0));
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'(w));
        chk({tag, ".out"}, 64'(out), 64'(exp_out));
        chk({tag, ".dz"}, 64'(dz), 64'(exp_dz));
        chk({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
            chk({tag, ".hold_out"}, 64'(out), 64'(exp_out));
            chk({tag, ".hold_flags"}, 64'({dz, ovf}), 64'({exp_dz, exp_ovf}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".drained_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".drained_in_ready"}, 64'(in_ready), 64'(1));
        $display("txn %s op=%0d A=0x%07h B=0x%07h out=0x%014h dz=%04b ovf=%04b lat=%0d",
                 tag, m, a, b, exp_out, exp_dz, exp_ovf, lat);
    endtask

    initial begin
        int          rises;
        logic [1:0]  m;
        logic [27:0] a, b, zmask;
        #12;
        chk("reset.in_ready", 64'(in_ready), 64'(1));
        chk("reset.out_valid", 64'(out_valid), 64'(0));
        chk("reset.out", 64'(out), 64'(0));
        chk("reset.flags", 64'({dz, ovf}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        // Accept on the very first rising edge after reset release.
        run_op(2'd0, 28'h8000000, 28'h8000000, 5, "unity_stall");
        run_op(2'd2, 28'h8102040, 28'hC183060, 0, "four_lane");
        run_op(2'd1, 28'h0002000, 28'h0002000, 0, "two_lane_dz");
        run_op(2'd0, 28'hFFFFFFF, 28'h0000001, 0, "ovf28");
        run_op(2'd3, 28'h5555555, 28'h7000000, 1, "op_reserved");
        run_op(2'd2, 28'h7F0407F, 28'h0000F10, 2, "mixed_flags");
        run_op(2'd1, 28'h3FFF001, 28'h2000001, 0, "two_lane_edge");

        // Abort a 28-bit operation during its 10th busy cycle.
        op = 2'd0;
        A = 28'h8000000;
        B = 28'h8000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", 64'(out_valid), 64'(0));
        chk("abort.out", 64'(out), 64'(0));
        chk("abort.flags", 64'({dz, ovf}), 64'(0));
        chk("abort.in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        rises = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        chk("abort.no_result", 64'(rises), 64'(0));
        run_op(2'd0, 28'h8000000, 28'h8000000, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            m = 2'($urandom_range(0, 3));
            a = 28'($urandom);
            b = 28'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                zmask = 28'h7F;
                zmask = zmask << (7 * $urandom_range(0, 3));
                b = b & ~zmask;
            end
            run_op(m, a, b, $urandom_range(0, 2), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
